wash_sequencer: RTL and testbench

//   Program sequencer for the washing-machine controller: owns the model selection, stage order,
//   per-stage countdown, run/pause state and completion flag. Produces current_model, current_program,
//   run_state and finish, which the panel light/buzzer logic consumes. Key inputs come from the panel

---
 rtl/wash_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
//
// Program sequencer for the washing-machine controller. It owns the model
// selection, the order of stages within the selected model, the per-stage
// and whole-program countdowns, the run/pause state and the completion flag.
// The panel light/buzzer logic consumes current_model, current_program,
// run_state and finish.
//
// Models (current_model) and the stages each one runs:
//   000 wash-rinse-spin   001 wash        010 wash-rinse
//   011 rinse             100 rinse-spin  101 spin
// Stage codes (current_program): 00 wash, 01 rinse, 10 spin.
//
// Ports
//   clk             in   1  system clock
//   reset           in   1  synchronous, active-high reset
//   power_on        in   1  power switch level; 0 holds the block cleared
//   tick_1hz        in   1  one-clk pulse per second from the clock divider
//   start_key       in   1  start/pause switch level; acts on rising edge
//   model_key       in   1  model-select switch level; acts on rising edge
//   clothes_key     in   1  add-clothes switch level; acts on rising edge
//   current_model   out  3  selected model (see table above)
//   current_program out  2  active stage
//   run_state       out  2  00 idle, 01 running or done, 10 paused
//   finish          out  1  high while the program has completed
//   stage_sec       out  8  seconds left in the current stage
//   remain_sec      out  8  seconds left in the whole program
//   state_dbg       out  2  raw FSM state (00 idle, 01 run, 10 pause, 11 done)
//
// Handshake: there is no valid/ready pair on this block. Keys are levels
// whose rising edge is the request; the request is taken in the clk it is
// first seen high, and the outputs reflect it from the following clk. The
// tick is a one-clk strobe consumed in the clk it is high.
//
// Per-clk priority: reset > power_on low > start > model > clothes > tick.
// When a higher-priority event causes a transition, lower-priority events
// in the same clk are dropped.
// -----------------------------------------------------------------------------
module wash_sequencer #(
    parameter int WASH_T  = 9,   // wash stage length, seconds (1..85)
    parameter int RINSE_T = 6,   // rinse stage length, seconds (1..85)
    parameter int SPIN_T  = 3    // spin stage length, seconds (1..85)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on,
    input  logic       tick_1hz,
    input  logic       start_key,
    input  logic       model_key,
    input  logic       clothes_key,
    output logic [2:0] current_model,
    output logic [1:0] current_program,
    output logic [1:0] run_state,
    output logic       finish,
    output logic [7:0] stage_sec,
    output logic [7:0] remain_sec,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PRG_WASH  = 2'b00;
    localparam logic [1:0] PRG_RINSE = 2'b01;
    localparam logic [1:0] PRG_SPIN  = 2'b10;

    localparam logic [2:0] MDL_WRS = 3'b000;
    localparam logic [2:0] MDL_W   = 3'b001;
    localparam logic [2:0] MDL_WR  = 3'b010;
    localparam logic [2:0] MDL_R   = 3'b011;
    localparam logic [2:0] MDL_RS  = 3'b100;
    localparam logic [2:0] MDL_S   = 3'b101;

    localparam logic [7:0] WASH_L  = 8'(WASH_T);
    localparam logic [7:0] RINSE_L = 8'(RINSE_T);
    localparam logic [7:0] SPIN_L  = 8'(SPIN_T);
    localparam logic [7:0] TOTAL_L = 8'(WASH_T + RINSE_T + SPIN_T);

    // -------------------------------------------------------------------------
    // Model/stage lookup helpers
    // -------------------------------------------------------------------------

    // Length in seconds of a stage.
    function automatic logic [7:0] stage_len(input logic [1:0] prg);
        case (prg)
            PRG_WASH:  stage_len = WASH_L;
            PRG_RINSE: stage_len = RINSE_L;
            default:   stage_len = SPIN_L;
        endcase
    endfunction

    // First stage a model runs.
    function automatic logic [1:0] first_prog(input logic [2:0] mdl);
        case (mdl)
            MDL_R, MDL_RS: first_prog = PRG_RINSE;
            MDL_S:         first_prog = PRG_SPIN;
            default:       first_prog = PRG_WASH;
        endcase
    endfunction

    // Sum of all stage lengths of a model.
    function automatic logic [7:0] model_total(input logic [2:0] mdl);
        case (mdl)
            MDL_W:   model_total = WASH_L;
            MDL_WR:  model_total = WASH_L + RINSE_L;
            MDL_R:   model_total = RINSE_L;
            MDL_RS:  model_total = RINSE_L + SPIN_L;
            MDL_S:   model_total = SPIN_L;
            default: model_total = TOTAL_L;
        endcase
    endfunction

    // Stage that follows prg within mdl. Bit 2 = a next stage exists,
    // bits 1:0 = its code. Stages only ever advance wash -> rinse -> spin,
    // so a model continues only if it contains the following stage.
    function automatic logic [2:0] next_stage(input logic [2:0] mdl,
                                              input logic [1:0] prg);
        next_stage = {1'b0, PRG_WASH};
        case (prg)
            PRG_WASH:
                if (mdl == MDL_WRS || mdl == MDL_WR)
                    next_stage = {1'b1, PRG_RINSE};
            PRG_RINSE:
                if (mdl == MDL_WRS || mdl == MDL_RS)
                    next_stage = {1'b1, PRG_SPIN};
            default:
                next_stage = {1'b0, PRG_WASH};
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Key edge detection
    // -------------------------------------------------------------------------
    logic start_q;
    logic model_q;
    logic clothes_q;
    logic start_edge;
    logic model_edge;
    logic clothes_edge;

    assign start_edge   = start_key   & ~start_q;
    assign model_edge   = model_key   & ~model_q;
    assign clothes_edge = clothes_key & ~clothes_q;

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    state_t     state;
    state_t     state_n;
    logic [2:0] model_n;
    logic [1:0] prog_n;
    logic [7:0] stage_n;
    logic [7:0] remain_n;
    logic [2:0] model_inc;
    logic [1:0] inc_first;
    logic [2:0] nxt;

    // -------------------------------------------------------------------------
    // Process 1: state register (FSM state plus the counters it steers)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // Edge registers always track the key levels, including while held in
        // reset or powered off, so a key held across power-up is not an edge.
        start_q   <= start_key;
        model_q   <= model_key;
        clothes_q <= clothes_key;

        if (reset || !power_on) begin
            state           <= S_IDLE;
            current_model   <= MDL_WRS;
            current_program <= PRG_WASH;
            stage_sec       <= WASH_L;
            remain_sec      <= TOTAL_L;
        end else begin
            state           <= state_n;
            current_model   <= model_n;
            current_program <= prog_n;
            stage_sec       <= stage_n;
            remain_sec      <= remain_n;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state and counter update logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        model_n  = current_model;
        prog_n   = current_program;
        stage_n  = stage_sec;
        remain_n = remain_sec;

        // 101 wraps to 000; the unreachable codes 110/111 also land on 000.
        model_inc = (current_model >= MDL_S) ? MDL_WRS : current_model + 3'd1;
        inc_first = first_prog(model_inc);
        nxt       = next_stage(current_model, current_program);

        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_n = S_RUN;
                end else if (model_edge) begin
                    model_n  = model_inc;
                    prog_n   = inc_first;
                    stage_n  = stage_len(inc_first);
                    remain_n = model_total(model_inc);
                end
            end

            S_RUN: begin
                if (start_edge) begin
                    state_n = S_PAUSE;
                end else if (tick_1hz) begin
                    remain_n = remain_sec - 8'd1;
                    if (stage_sec == 8'd1) begin
                        if (nxt[2]) begin
                            prog_n  = nxt[1:0];
                            stage_n = stage_len(nxt[1:0]);
                        end else begin
                            state_n  = S_DONE;
                            model_n  = MDL_WRS;
                            prog_n   = PRG_WASH;
                            stage_n  = 8'd0;
                            remain_n = 8'd0;
                        end
                    end else begin
                        stage_n = stage_sec - 8'd1;
                    end
                end
            end

            S_PAUSE: begin
                if (start_edge) begin
                    state_n = S_RUN;
                end else if (clothes_edge && current_program == PRG_WASH) begin
                    // Adding clothes restarts the wash stage; the program total
                    // grows by the wash time already spent.
                    stage_n  = WASH_L;
                    remain_n = remain_sec - stage_sec + WASH_L;
                end
            end

            S_DONE: begin
                // A model edge here only leaves DONE; it does not also advance
                // the model.
                if (start_edge || model_edge) begin
                    state_n  = S_IDLE;
                    model_n  = MDL_WRS;
                    prog_n   = PRG_WASH;
                    stage_n  = WASH_L;
                    remain_n = TOTAL_L;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output decode from the state register
    // -------------------------------------------------------------------------
    always_comb begin
        run_state = 2'b00;
        finish    = 1'b0;
        case (state)
            S_RUN:   run_state = 2'b01;
            S_PAUSE: run_state = 2'b10;
            S_DONE: begin
                run_state = 2'b01;
                finish    = 1'b1;
            end
            default: run_state = 2'b00;
        endcase
        state_dbg = state;
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_sequencer
//
// Directed bench for wash_sequencer with default stage lengths
// (wash 9, rinse 6, spin 3). Driver tasks apply key/tick pulses and push the
// hand-computed expected output snapshot into exp_q; a monitor on the falling
// clock edge pops each entry and compares it with the DUT outputs.
// Snapshot layout: {model[2:0], program[1:0], run_state[1:0], finish,
//                   stage_sec[7:0], remain_sec[7:0]}.
// -----------------------------------------------------------------------------
module tb_wash_sequencer;

    logic       clk;
    logic       reset;
    logic       power_on;
    logic       tick_1hz;
    logic       start_key;
    logic       model_key;
    logic       clothes_key;
    logic [2:0] current_model;
    logic [1:0] current_program;
    logic [1:0] run_state;
    logic       finish;
    logic [7:0] stage_sec;
    logic [7:0] remain_sec;
    logic [1:0] state_dbg;

    wash_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .power_on        (power_on),
        .tick_1hz        (tick_1hz),
        .start_key       (start_key),
        .model_key       (model_key),
        .clothes_key     (clothes_key),
        .current_model   (current_model),
        .current_program (current_program),
        .run_state       (run_state),
        .finish          (finish),
        .stage_sec       (stage_sec),
        .remain_sec      (remain_sec),
        .state_dbg       (state_dbg)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ----------------------------------------------------------- scoreboard
    logic [23:0] exp_q[$];
    string       name_q[$];
    int          n_cmp;
    int          n_err;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [23:0] e;
            logic [23:0] got;
            string       nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {current_model, current_program, run_state, finish,
                   stage_sec, remain_sec};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got m=%b p=%b rs=%b f=%b st=%0d rem=%0d, expected m=%b p=%b rs=%b f=%b st=%0d rem=%0d",
                         nm, got[23:21], got[20:19], got[18:17], got[16],
                         got[15:8], got[7:0], e[23:21], e[20:19], e[18:17],
                         e[16], e[15:8], e[7:0]);
            end
        end
    end

    // --------------------------------------------------------- driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive the given levels for one clk, then release all for one clk so the
    // next pulse is seen as a fresh edge.
    task automatic press(input logic s, input logic m, input logic c,
                         input logic t);
        start_key   = s;
        model_key   = m;
        clothes_key = c;
        tick_1hz    = t;
        cyc();
        start_key   = 1'b0;
        model_key   = 1'b0;
        clothes_key = 1'b0;
        tick_1hz    = 1'b0;
        cyc();
    endtask

    task automatic expect_out(input string nm, input logic [2:0] m,
                              input logic [1:0] p, input logic [1:0] rs,
                              input logic f, input logic [7:0] st,
                              input logic [7:0] rem);
        exp_q.push_back({m, p, rs, f, st, rem});
        name_q.push_back(nm);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        power_on    = 1'b1;
        tick_1hz    = 1'b0;
        start_key   = 1'b0;
        model_key   = 1'b0;
        clothes_key = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        expect_out("reset", 3'b000, 2'b00, 2'b00, 1'b0, 8'd9, 8'd18);
        cyc();

        // Tick in IDLE does nothing.
        press(0, 0, 0, 1);
        expect_out("idle_tick", 3'b000, 2'b00, 2'b00, 1'b0, 8'd9, 8'd18);

        // Model cycling through all six models and wrapping.
        press(0, 1, 0, 0);
        expect_out("model_001", 3'b001, 2'b00, 2'b00, 1'b0, 8'd9, 8'd9);
        press(0, 1, 0, 0);
        expect_out("model_010", 3'b010, 2'b00, 2'b00, 1'b0, 8'd9, 8'd15);
        press(0, 1, 0, 0);
        expect_out("model_011", 3'b011, 2'b01, 2'b00, 1'b0, 8'd6, 8'd6);
        press(0, 1, 0, 0);
        expect_out("model_100", 3'b100, 2'b01, 2'b00, 1'b0, 8'd6, 8'd9);
        press(0, 1, 0, 0);
        expect_out("model_101", 3'b101, 2'b10, 2'b00, 1'b0, 8'd3, 8'd3);
        press(0, 1, 0, 0);
        expect_out("model_wrap", 3'b000, 2'b00, 2'b00, 1'b0, 8'd9, 8'd18);

        // Full run of model 000.
        press(1, 0, 0, 0);
        expect_out("start_run", 3'b000, 2'b00, 2'b01, 1'b0, 8'd9, 8'd18);
        for (int k = 1; k <= 18; k++) begin
            press(0, 0, 0, 1);
            if (k < 9)
                expect_out("run_wash", 3'b000, 2'b00, 2'b01, 1'b0,
                           8'(9 - k), 8'(18 - k));
            else if (k < 15)
                expect_out("run_rinse", 3'b000, 2'b01, 2'b01, 1'b0,
                           8'(15 - k), 8'(18 - k));
            else if (k < 18)
                expect_out("run_spin", 3'b000, 2'b10, 2'b01, 1'b0,
                           8'(18 - k), 8'(18 - k));
            else
                expect_out("done", 3'b000, 2'b00, 2'b01, 1'b1, 8'd0, 8'd0);
        end
        press(0, 0, 0, 1);
        expect_out("done_tick", 3'b000, 2'b00, 2'b01, 1'b1, 8'd0, 8'd0);

        // Model edge leaves DONE without incrementing.
        press(0, 1, 0, 0);
        expect_out("done_model", 3'b000, 2'b00, 2'b00, 1'b0, 8'd9, 8'd18);

        // Pause in wash, add clothes.
        press(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) press(0, 0, 0, 1);
        expect_out("run_4", 3'b000, 2'b00, 2'b01, 1'b0, 8'd5, 8'd14);
        press(1, 0, 0, 0);
        expect_out("pause", 3'b000, 2'b00, 2'b10, 1'b0, 8'd5, 8'd14);
        for (int k = 0; k < 5; k++) press(0, 0, 0, 1);
        expect_out("pause_ticks", 3'b000, 2'b00, 2'b10, 1'b0, 8'd5, 8'd14);
        press(0, 0, 1, 0);
        expect_out("clothes_wash", 3'b000, 2'b00, 2'b10, 1'b0, 8'd9, 8'd18);
        press(1, 0, 0, 0);
        expect_out("resume", 3'b000, 2'b00, 2'b01, 1'b0, 8'd9, 8'd18);

        // Pause in rinse: clothes and model ignored.
        for (int k = 0; k < 9; k++) press(0, 0, 0, 1);
        expect_out("rinse_entry", 3'b000, 2'b01, 2'b01, 1'b0, 8'd6, 8'd9);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        expect_out("clothes_rinse", 3'b000, 2'b01, 2'b10, 1'b0, 8'd6, 8'd9);
        press(0, 1, 0, 0);
        expect_out("pause_model", 3'b000, 2'b01, 2'b10, 1'b0, 8'd6, 8'd9);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        expect_out("run_model", 3'b000, 2'b01, 2'b01, 1'b0, 8'd6, 8'd9);

        // Start and tick together in RUN: pause wins, tick dropped.
        press(1, 0, 0, 1);
        expect_out("start_tick", 3'b000, 2'b01, 2'b10, 1'b0, 8'd6, 8'd9);
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        expect_out("run_tick", 3'b000, 2'b01, 2'b01, 1'b0, 8'd5, 8'd8);

        // Power off mid-run with start held through power-up.
        power_on  = 1'b0;
        start_key = 1'b1;
        cyc();
        expect_out("power_off", 3'b000, 2'b00, 2'b00, 1'b0, 8'd9, 8'd18);
        power_on = 1'b1;
        cyc();
        cyc();
        expect_out("held_start", 3'b000, 2'b00, 2'b00, 1'b0, 8'd9, 8'd18);
        start_key = 1'b0;
        cyc();
        press(1, 0, 0, 0);
        expect_out("start_after", 3'b000, 2'b00, 2'b01, 1'b0, 8'd9, 8'd18);

        // Reset mid-run, then start and model together in IDLE.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_out("reset_run", 3'b000, 2'b00, 2'b00, 1'b0, 8'd9, 8'd18);
        cyc();
        press(1, 1, 0, 0);
        expect_out("start_model", 3'b000, 2'b00, 2'b01, 1'b0, 8'd9, 8'd18);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: got %0d entries left, expected 0",
                     exp_q.size());
            n_err += exp_q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
